sopc_run_ctrl: RTL and testbench
================================

// Module: sopc_run_ctrl
// PURPOSE
//   Parametrised run controller for the minimal SOPC. Holds the core in reset for a set number of cycles after start,
//   releases it, and bounds the run by a cycle budget or by PC-stall halt detection. Counts register write-backs,
//   then re-asserts core reset and reports completion. Sits between the board/bench clock-reset source and openmips_min_sopc.
// PARAMETERS
//   PC_W         32    width of monitored PC
//   CNT_W        32    width of cycle and write-back counters
//   RST_CYCLES   8     cycles core_rst_o is held after start (>=1)
//   RUN_CYCLES   400   run budget in cycles (>=1)
//   STALL_LIMIT  16    consecutive unchanged-PC cycles that mean halt (>=2)
//   DRAIN_CYCLES 4     cycles the core keeps running after halt/timeout, letting the pipeline retire (>=0)
// PORTS
//   clk          in   1      clock
//   rst          in   1      asynchronous reset, active-low
//   start_i      in   1      one-cycle start request; honoured only in IDLE
//   pc_i         in   PC_W   core fetch PC
//   wb_we_i      in   1      regfile write enable
//   wb_addr_i    in   5      regfile write address
//   wb_data_i    in   32     regfile write data
//   core_rst_o   out  1      core reset, active-high (RstEnable)
//   running_o    out  1      high in RUN and DRAIN
//   done_o       out  1      one-cycle pulse on completion
//   halted_o     out  1      sticky: run ended by PC stall
//   timeout_o    out  1      sticky: run ended by budget
//   cycle_cnt_o  out  CNT_W  cycles spent in RUN
//   wb_cnt_o     out  CNT_W  write-backs counted, saturating
//   checksum_o   out  32     write-back signature (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst=0, any time, mid-run too): state IDLE, core_rst_o=1, all other outputs and counters 0.
//   - Outputs are registered; every state output changes one cycle after the triggering edge.
//   - IDLE: core_rst_o=1. start_i=1 -> RESET: load rst counter = RST_CYCLES-1, clear cycle_cnt, wb_cnt, checksum, halted, timeout.
//   - RESET: core_rst_o=1; counter decrements; at 0 -> RUN. core_rst_o is high for exactly RST_CYCLES cycles after start.
//   - RUN: core_rst_o=0, running_o=1; cycle_cnt +1 per cycle.
//     Stall counter clears when pc_i differs from the previous cycle, else +1.
//     Stall count reaching STALL_LIMIT-1 -> halted_o=1, go to DRAIN.
//     cycle_cnt reaching RUN_CYCLES-1 -> timeout_o=1, go to DRAIN.
//     Both in the same cycle: halted_o wins, timeout_o stays 0.
//   - DRAIN: core still running; counter = DRAIN_CYCLES; at 0 (or immediately if 0) -> DONE. cycle_cnt frozen.
//   - DONE: core_rst_o=1, running_o=0, done_o=1 for one cycle -> IDLE. Counters and flags hold until the next start.
//   - start_i outside IDLE is ignored.
//   - Write-back counting: wb_we_i=1 and wb_addr_i!=0 in RUN or DRAIN -> wb_cnt +1, saturating at all-ones.
//     Writes to $0 are not counted.
//   - cycle_cnt cannot wrap: RUN_CYCLES must fit in CNT_W; out-of-range value is a configuration error.
// CONFIGURATION
//   WB_CHECKSUM_EN defined:
//     each counted write-back updates chk <= {chk[30:0],chk[31]} ^ wb_data_i ^ {27'b0,wb_addr_i}.
//     checksum_o = chk, cleared on start and on reset.
//   WB_CHECKSUM_EN undefined: no checksum logic; checksum_o tied to 32'h0.
// TESTING
//   1 Reset mid-run: pulse rst=0 during RUN -> core_rst_o=1 within that cycle (async); all counters 0, state IDLE.
//   2 Budget: RST_CYCLES=8, RUN_CYCLES=20, pc_i incrementing by 4 each cycle, start at cycle 0
//     -> core_rst_o low from cycle 9; timeout_o=1, cycle_cnt_o=20;
//     done_o pulses DRAIN_CYCLES+1 cycles after leaving RUN.
//   3 Halt: pc_i frozen at 32'h0000_0040 from RUN cycle 5, STALL_LIMIT=16
//     -> halted_o=1, timeout_o=0, cycle_cnt_o=5+15; core_rst_o returns to 1 at DONE.
//   4 Write-backs: 3 writes (addr 1,2,3) plus 1 write to $0, plus 1 write in IDLE -> wb_cnt_o=3.
//     With WB_CHECKSUM_EN, data 1,2,3 -> checksum_o matches a bench model of the rotate-xor.
//   5 Start ignored: start_i pulsed in RUN and DRAIN -> no restart; done_o pulses exactly once.
//   6 Tie-break: halt and budget limit coincide in the same cycle -> halted_o=1, timeout_o=0.

Source files
------------

// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl -- run controller for the minimal SOPC.
//   Holds the core in reset for RST_CYCLES after start, then lets it run until
//   either the PC stalls for STALL_LIMIT consecutive cycles (halt) or the
//   RUN_CYCLES budget is spent (timeout). It keeps the core running for a short
//   drain period, re-asserts core reset and pulses done_o. Register write-backs
//   seen while the core runs are counted.
// Optional feature: define WB_CHECKSUM_EN to build the rotate-xor write-back
//   signature on checksum_o; without it checksum_o is tied to zero.
// Ports:
//   clk          clock
//   rst          asynchronous reset, active-low
//   start_i      start request, honoured only in IDLE
//   pc_i         core fetch PC
//   wb_we_i      regfile write enable
//   wb_addr_i    regfile write address
//   wb_data_i    regfile write data
//   core_rst_o   core reset, active-high
//   running_o    core running (RUN or DRAIN)
//   done_o       one-cycle completion pulse
//   halted_o     sticky: run ended by PC stall
//   timeout_o    sticky: run ended by cycle budget
//   cycle_cnt_o  cycles spent in RUN
//   wb_cnt_o     counted write-backs, saturating
//   checksum_o   write-back signature
module sopc_run_ctrl #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned RUN_CYCLES   = 400,
  parameter int unsigned STALL_LIMIT  = 16,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_addr_i,
  input  logic [31:0]      wb_data_i,
  output logic             core_rst_o,
  output logic             running_o,
  output logic             done_o,
  output logic             halted_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o,
  output logic [31:0]      checksum_o
);

  localparam int unsigned STALL_W = $clog2(STALL_LIMIT) + 1;

  if (RST_CYCLES < 1 || RUN_CYCLES < 1 || STALL_LIMIT < 2) begin : g_bad_param
    $error("sopc_run_ctrl: RST_CYCLES/RUN_CYCLES must be >=1 and STALL_LIMIT >=2");
  end
  if ((CNT_W < 32) && (64'(RUN_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_budget
    $error("sopc_run_ctrl: RUN_CYCLES does not fit in CNT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   dly_q, dly_d;       // shared by RESET and DRAIN
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   wb_q, wb_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [PC_W-1:0]    pc_prev_q;
  logic               halted_q, halted_d;
  logic               timeout_q, timeout_d;
  logic               core_rst_q, running_q, done_q;
  logic               clr;
  logic               wb_hit;
  logic               core_on_d;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cycle_d   = cycle_q;
    stall_d   = '0;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    clr       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_RESET;
          dly_d     = CNT_W'(RST_CYCLES - 1);
          cycle_d   = '0;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
          clr       = 1'b1;
        end
      end
      S_RESET: begin
        if (dly_q == '0) state_d = S_RUN;
        else             dly_d   = dly_q - 1'b1;
      end
      S_RUN: begin
        cycle_d = cycle_q + 1'b1;
        stall_d = (pc_i == pc_prev_q) ? stall_q + 1'b1 : '0;
        // Halt is tested first so it wins when both limits land together.
        if (stall_d == STALL_W'(STALL_LIMIT - 1)) begin
          halted_d = 1'b1;
          state_d  = S_DRAIN;
          dly_d    = CNT_W'(DRAIN_CYCLES);
        end else if (cycle_q == CNT_W'(RUN_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DRAIN;
          dly_d     = CNT_W'(DRAIN_CYCLES);
        end
      end
      S_DRAIN: begin
        if (dly_q == '0) state_d = S_DONE;
        else             dly_d   = dly_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_hit = (state_q == S_RUN || state_q == S_DRAIN) && wb_we_i && (wb_addr_i != '0);

  always_comb begin
    wb_d = wb_q;
    if (clr)                        wb_d = '0;
    else if (wb_hit && wb_q != '1)  wb_d = wb_q + 1'b1;
  end

  // Outputs are decoded from the next state so they register with the state.
  assign core_on_d = (state_d == S_RUN) || (state_d == S_DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      dly_q      <= '0;
      cycle_q    <= '0;
      wb_q       <= '0;
      stall_q    <= '0;
      pc_prev_q  <= '0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      cycle_q    <= cycle_d;
      wb_q       <= wb_d;
      stall_q    <= stall_d;
      pc_prev_q  <= pc_i;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
      core_rst_q <= !core_on_d;
      running_q  <= core_on_d;
      done_q     <= (state_d == S_DONE);
    end
  end

`ifdef WB_CHECKSUM_EN
  logic [31:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (clr)         chk_d = '0;
    else if (wb_hit) chk_d = {chk_q[30:0], chk_q[31]} ^ wb_data_i ^ {27'b0, wb_addr_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chk_q <= '0;
    else      chk_q <= chk_d;
  end

  assign checksum_o = chk_q;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data_i;
  assign checksum_o     = '0;
`endif

  assign core_rst_o  = core_rst_q;
  assign running_o   = running_q;
  assign done_o      = done_q;
  assign halted_o    = halted_q;
  assign timeout_o   = timeout_q;
  assign cycle_cnt_o = cycle_q;
  assign wb_cnt_o    = wb_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
module tb_sopc_run_ctrl;

  localparam int unsigned RSTC  = 8;
  localparam int unsigned RUNC  = 20;
  localparam int unsigned STALL = 16;
  localparam int unsigned DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_addr_i = 5'd0;
  logic [31:0] wb_data_i = 32'h0;
  logic        core_rst_o, running_o, done_o, halted_o, timeout_o;
  logic [31:0] cycle_cnt_o, wb_cnt_o, checksum_o;

  always #5 clk = ~clk;

  sopc_run_ctrl #(
    .PC_W        (32),
    .CNT_W       (32),
    .RST_CYCLES  (RSTC),
    .RUN_CYCLES  (RUNC),
    .STALL_LIMIT (STALL),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .pc_i       (pc_i),
    .wb_we_i    (wb_we_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .core_rst_o (core_rst_o),
    .running_o  (running_o),
    .done_o     (done_o),
    .halted_o   (halted_o),
    .timeout_o  (timeout_o),
    .cycle_cnt_o(cycle_cnt_o),
    .wb_cnt_o   (wb_cnt_o),
    .checksum_o (checksum_o)
  );

  typedef struct {
    logic [31:0] cyc;
    logic [31:0] wb;
    logic [31:0] chk;
    logic        halted;
    logic        timeout;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp  = 0;
  int unsigned n_bad  = 0;
  int unsigned n_done = 0;
  logic [31:0] pc_base = 32'h0000_1000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] chk_step(input logic [31:0] c, input logic [31:0] d,
                                           input logic [4:0] a);
    return {c[30:0], c[31]} ^ d ^ {27'b0, a};
  endfunction

  task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic we);
    wb_we_i   = we;
    wb_addr_i = a;
    wb_data_i = d;
  endtask

  task automatic next_pc();
    pc_base = pc_base + 32'd4;
    pc_i    = pc_base;
  endtask

  // Scoreboard monitor: every done pulse consumes one expected run result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done_o=1 expected no pending run (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("done_cycle_cnt", cycle_cnt_o, e.cyc);
          check("done_wb_cnt",    wb_cnt_o,    e.wb);
          check("done_checksum",  checksum_o,  e.chk);
          check("done_halted",    halted_o,    e.halted);
          check("done_timeout",   timeout_o,   e.timeout);
          check("done_core_rst",  core_rst_o,  1);
          check("done_running",   running_o,   0);
        end
      end
    end
  end

  // kind 0: budget timeout with write-backs; 1: PC halt; 2: halt/budget tie with ignored starts
  task automatic run_case(input int unsigned kind);
    int unsigned freeze, rc, done_j;
    exp_t        e;
    logic [31:0] c;
    freeze = (kind == 1) ? 3 : (kind == 2) ? 5 : 0;
    rc     = (kind == 1) ? 18 : 20;
    done_j = RSTC + rc + DRAIN + 2;
    c      = '0;
    e.cyc     = rc;
    e.halted  = (kind != 0);
    e.timeout = (kind == 0);
    case (kind)
      0: begin
        c = chk_step(c, 32'hA5A5_0001, 5'd1);
        c = chk_step(c, 32'h0000_0F02, 5'd2);
        c = chk_step(c, 32'h8000_0003, 5'd3);
        e.wb = 3;
      end
      1: begin
        c = chk_step(c, 32'h0000_1234, 5'd7);
        e.wb = 1;
      end
      default: e.wb = 0;
    endcase
`ifdef WB_CHECKSUM_EN
    e.chk = c;
`else
    e.chk = '0;
`endif
    @(negedge clk);
    sb.push_back(e);
    start_i = 1'b1;
    next_pc();
    for (int unsigned j = 1; j <= done_j + 3; j++) begin
      @(negedge clk);
      start_i = 1'b0;
      wb(5'd0, 32'h0, 1'b0);
      if (j == RSTC)       check("core_rst_held",    core_rst_o, 1);
      if (j == RSTC + 1)   check("core_rst_release", core_rst_o, 0);
      if (j == RSTC + 1)   check("running_start",    running_o,  1);
      if (j == done_j - 1) check("done_early",       done_o,     0);
      if (j == done_j)     check("done_pulse",       done_o,     1);
      if (j == done_j + 1) check("done_single",      done_o,     0);
      case (kind)
        0: begin
          if (j == 10) wb(5'd1, 32'hA5A5_0001, 1'b1);
          if (j == 11) wb(5'd2, 32'h0000_0F02, 1'b1);
          if (j == 12) wb(5'd0, 32'hDEAD_BEEF, 1'b1);
          if (j == 13) wb(5'd3, 32'h8000_0003, 1'b1);
          if (j == done_j + 1) wb(5'd5, 32'h0000_0077, 1'b1);
        end
        1: begin
          if (j == 15)     wb(5'd4, 32'h0000_00FF, 1'b0);
          if (j == 28)     wb(5'd7, 32'h0000_1234, 1'b1);
          if (j == done_j) wb(5'd9, 32'h0000_0999, 1'b1);
        end
        default: begin
          if (j == 12 || j == 30) start_i = 1'b1;
          if (j == 30) check("drain_cycle_frozen", cycle_cnt_o, 20);
          if (j == 30) check("drain_running",      running_o,   1);
        end
      endcase
      if (freeze != 0 && j >= RSTC + freeze) pc_i = 32'h0000_0040;
      else                                   next_pc();
    end
    check("hold_cycle_cnt", cycle_cnt_o, rc);
    check("hold_wb_cnt",    wb_cnt_o,    e.wb);
    check("hold_halted",    halted_o,    e.halted);
    check("hold_timeout",   timeout_o,   e.timeout);
    check("idle_core_rst",  core_rst_o,  1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    @(negedge clk);
    check("reset_core_rst", core_rst_o,  1);
    check("reset_running",  running_o,   0);
    check("reset_done",     done_o,      0);
    check("reset_cycle",    cycle_cnt_o, 0);
    check("reset_wb",       wb_cnt_o,    0);
    check("reset_checksum", checksum_o,  0);
    rst = 1'b1;
    repeat (3) begin @(negedge clk); next_pc(); end

    run_case(0);
    run_case(1);
    run_case(2);

    // Reset in IDLE must clear results held from the previous run.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_rst_halted", halted_o,    0);
    check("idle_rst_cycle",  cycle_cnt_o, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of RUN.
    @(negedge clk);
    start_i = 1'b1;
    next_pc();
    for (int unsigned j = 1; j <= 13; j++) begin
      @(negedge clk);
      start_i = 1'b0;
      wb(5'd0, 32'h0, 1'b0);
      if (j == 10) wb(5'd1, 32'h0000_0055, 1'b1);
      next_pc();
    end
    check("midrun_cycle", cycle_cnt_o, 4);
    check("midrun_wb",    wb_cnt_o,    1);
    wb(5'd0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrun_rst_core_rst", core_rst_o,  1);
    check("midrun_rst_running",  running_o,   0);
    check("midrun_rst_cycle",    cycle_cnt_o, 0);
    check("midrun_rst_wb",       wb_cnt_o,    0);
    check("midrun_rst_checksum", checksum_o,  0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) begin @(negedge clk); next_pc(); end
    check("post_rst_idle_core_rst", core_rst_o,  1);
    check("post_rst_idle_running",  running_o,   0);
    check("post_rst_idle_cycle",    cycle_cnt_o, 0);

    run_case(0);

    repeat (5) @(negedge clk);
    check("done_pulse_count",  n_done,    4);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
